in_row: RTL and testbench



---
 rtl/in_row_if.sv | 22 ++
 rtl/in_row.sv | 82 ++++++++
 tb/tb_in_row.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/in_row_if.sv
// Row-source handshake bundle: per-lane write/out from the source, wready strobes back
// from the consuming grid column.
interface in_row_if #(
   parameter int LANES = 4,
   parameter int WIDTH = 11
);
   logic [LANES-1:0]        write;
   logic [LANES-1:0]        wready;
   logic signed [WIDTH-1:0] out [LANES];

   modport master (
      output write,
      output out,
      input  wready
   );

   modport slave (
      input  write,
      input  out,
      output wready
   );
endinterface

// File: rtl/in_row.sv
// Input-row source for the core grid: each lane streams its own slice of a preloaded
// word table into a grid column, one word per wready strobe.
module in_row #(
   parameter int LANES = 4,
   parameter int WIDTH = 11,
   parameter int SLICE = 64
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [$clog2(SLICE)-1:0]  length [LANES],
   input  logic signed [WIDTH-1:0]   data   [LANES*SLICE],
   in_row_if.master                  bus
);
   localparam int CNT_W = $clog2(SLICE);
   localparam int IDX_W = $clog2(LANES*SLICE);

   logic [CNT_W-1:0]        cnt_q   [LANES];
   logic [CNT_W-1:0]        cnt_d   [LANES];
   logic [LANES-1:0]        write_q;
   logic [LANES-1:0]        write_d;
   logic signed [WIDTH-1:0] out_q   [LANES];
   logic signed [WIDTH-1:0] out_d   [LANES];
   logic [LANES-1:0]        xfer;
   logic [IDX_W-1:0]        idx     [LANES];

   // Saturating advance: the index can never wrap back to word 0 of the slice.
   function automatic logic [CNT_W-1:0] cnt_adv(input logic [CNT_W-1:0] cnt,
                                                input logic             take);
      if (take && (cnt != '1))
         return cnt + CNT_W'(1);
      return cnt;
   endfunction

   function automatic logic [IDX_W-1:0] tbl_idx(input int               lane,
                                                input logic [CNT_W-1:0] cnt);
      return IDX_W'(lane * SLICE) + IDX_W'(cnt);
   endfunction

   always_comb begin
      xfer    = '0;
      write_d = '0;
      for (int i = 0; i < LANES; i++) begin
         cnt_d[i] = cnt_q[i];
         out_d[i] = out_q[i];
         idx[i]   = '0;
      end

      // The word after a transfer is fetched in the same cycle, so a held wready drains
      // one word per clock; length is compared live so run-time edits take effect at once.
      for (int i = 0; i < LANES; i++) begin
         xfer[i]    = write_q[i] & bus.wready[i];
         cnt_d[i]   = cnt_adv(cnt_q[i], xfer[i]);
         write_d[i] = (cnt_d[i] < length[i]);
         idx[i]     = tbl_idx(i, cnt_d[i]);
         if (write_d[i])
            out_d[i] = data[idx[i]];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         write_q <= '0;
         for (int i = 0; i < LANES; i++) begin
            cnt_q[i] <= '0;
            out_q[i] <= '0;
         end
      end else begin
         write_q <= write_d;
         for (int i = 0; i < LANES; i++) begin
            cnt_q[i] <= cnt_d[i];
            out_q[i] <= out_d[i];
         end
      end
   end

   assign bus.write = write_q;

   always_comb begin
      for (int i = 0; i < LANES; i++)
         bus.out[i] = out_q[i];
   end
endmodule

// File: tb/tb_in_row.sv
// Directed bench for in_row: expected words are queued per lane as stimulus is set up
// and compared whenever a lane completes a write/wready transfer.
module tb_in_row;
   localparam int LANES = 4;
   localparam int WIDTH = 11;
   localparam int SLICE = 64;

   logic clk = 1'b0;
   logic rst;
   logic [5:0]              length [LANES];
   logic signed [WIDTH-1:0] data   [LANES*SLICE];

   always #5 clk = ~clk;

   in_row_if #(.LANES(LANES), .WIDTH(WIDTH)) bus ();

   in_row #(.LANES(LANES), .WIDTH(WIDTH), .SLICE(SLICE)) dut (
      .clk    (clk),
      .rst    (rst),
      .length (length),
      .data   (data),
      .bus    (bus)
   );

   int exp_q [LANES][$];
   int n_pass  = 0;
   int n_total = 0;

   task automatic chk(input string tag, input int obs, input int exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   task automatic push(input int lane, input int k);
      exp_q[lane].push_back(int'(data[lane*SLICE + k]));
   endtask

   task automatic flush();
      for (int i = 0; i < LANES; i++) exp_q[i].delete();
   endtask

   task automatic drained(input string tag);
      for (int i = 0; i < LANES; i++)
         chk($sformatf("%s_left_lane%0d", tag, i), exp_q[i].size(), 0);
   endtask

   // Score any transfer that the coming edge will perform, then advance one cycle.
   task automatic tick();
      int e;
      for (int i = 0; i < LANES; i++) begin
         if (!rst && bus.write[i] && bus.wready[i]) begin
            if (exp_q[i].size() == 0) begin
               chk($sformatf("extra_word_lane%0d", i), 1, 0);
            end else begin
               e = exp_q[i].pop_front();
               chk($sformatf("word_lane%0d", i), int'(bus.out[i]), e);
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      int c;
      rst        = 1'b1;
      bus.wready = '0;
      length     = '{6'd5, 6'd0, 6'd0, 6'd0};
      for (int k = 0; k < LANES*SLICE; k++) data[k] = WIDTH'(k*97 - 1000);
      for (int k = 0; k < 5; k++) data[k] = WIDTH'(k);
      tick();
      tick();

      // Reset state
      for (int i = 0; i < LANES; i++) begin
         chk($sformatf("rst_write%0d", i), int'(bus.write[i]), 0);
         chk($sformatf("rst_out%0d", i), int'(bus.out[i]), 0);
      end

      // Basic stream with wready held high
      bus.wready = 4'b0001;
      for (int k = 0; k < 5; k++) push(0, k);
      rst = 1'b0;
      tick();
      chk("t1_first_write", int'(bus.write[0]), 1);
      chk("t1_first_out", int'(bus.out[0]), 0);
      c = 0;
      for (int n = 0; n < 8; n++) begin
         if (bus.write[0]) c++;
         tick();
      end
      chk("t1_write_cycles", c, 5);
      chk("t1_end_write", int'(bus.write[0]), 0);
      chk("t1_end_out", int'(bus.out[0]), 4);
      for (int i = 1; i < LANES; i++) begin
         chk($sformatf("t1_idle_write%0d", i), int'(bus.write[i]), 0);
         chk($sformatf("t1_idle_out%0d", i), int'(bus.out[i]), 0);
      end
      drained("t1");

      // Stalled consumer, then a single strobe
      rst = 1'b1; bus.wready = '0; flush();
      tick();
      rst = 1'b0;
      tick();
      for (int n = 0; n < 10; n++) begin
         chk("t2_stall_write", int'(bus.write[0]), 1);
         chk("t2_stall_out", int'(bus.out[0]), 0);
         tick();
      end
      push(0, 0);
      bus.wready[0] = 1'b1;
      tick();
      bus.wready[0] = 1'b0;
      chk("t2_next_out", int'(bus.out[0]), 1);
      chk("t2_next_write", int'(bus.write[0]), 1);
      drained("t2");

      // Reset in the middle of a stream
      rst = 1'b1; flush();
      tick();
      rst = 1'b0; bus.wready[0] = 1'b1;
      push(0, 0); push(0, 1);
      tick();
      tick();
      tick();
      chk("t4_mid_out", int'(bus.out[0]), 2);
      rst = 1'b1; bus.wready = '0;
      tick();
      chk("t4_rst_write", int'(bus.write[0]), 0);
      chk("t4_rst_out", int'(bus.out[0]), 0);
      drained("t4a");
      rst = 1'b0; bus.wready[0] = 1'b1;
      for (int k = 0; k < 5; k++) push(0, k);
      tick();
      chk("t4_restart_write", int'(bus.write[0]), 1);
      chk("t4_restart_out", int'(bus.out[0]), 0);
      for (int n = 0; n < 6; n++) tick();
      chk("t4_end_write", int'(bus.write[0]), 0);
      chk("t4_end_out", int'(bus.out[0]), 4);
      drained("t4b");

      // Lane slicing with signed boundary words
      rst = 1'b1; bus.wready = '0; flush();
      length = '{6'd1, 6'd2, 6'd3, 6'd1};
      data[64]  = -11'sd5;    data[65]  = 11'sd7;
      data[128] = 11'sd100;   data[129] = -11'sd1024; data[130] = 11'sd1023;
      data[192] = -11'sd1;
      tick();
      rst = 1'b0; bus.wready = 4'b1111;
      push(0, 0);
      push(1, 0); push(1, 1);
      push(2, 0); push(2, 1); push(2, 2);
      push(3, 0);
      tick();
      chk("t3_write_c1", int'(bus.write), 4'b1111);
      tick();
      chk("t3_write_c2", int'(bus.write), 4'b0110);
      tick();
      chk("t3_write_c3", int'(bus.write), 4'b0100);
      tick();
      chk("t3_write_c4", int'(bus.write), 4'b0000);
      chk("t3_hold_out1", int'(bus.out[1]), 7);
      chk("t3_hold_out2", int'(bus.out[2]), 1023);
      chk("t3_hold_out3", int'(bus.out[3]), -1);
      drained("t3");

      // Spurious strobes on empty lanes
      rst = 1'b1; bus.wready = '0; flush();
      length = '{6'd3, 6'd0, 6'd2, 6'd0};
      tick();
      rst = 1'b0;
      tick();
      for (int n = 0; n < 20; n++) begin
         bus.wready[1] = 1'($urandom_range(0, 1));
         bus.wready[3] = 1'($urandom_range(0, 1));
         chk("t5_write1", int'(bus.write[1]), 0);
         chk("t5_out1", int'(bus.out[1]), 0);
         chk("t5_write0", int'(bus.write[0]), 1);
         chk("t5_out0", int'(bus.out[0]), int'(data[0]));
         chk("t5_out2", int'(bus.out[2]), int'(data[128]));
         tick();
      end
      bus.wready = 4'b0101;
      for (int k = 0; k < 3; k++) push(0, k);
      for (int k = 0; k < 2; k++) push(2, k);
      for (int n = 0; n < 4; n++) tick();
      chk("t5_end_write", int'(bus.write), 0);
      drained("t5");

      // Length raised after the lane is exhausted
      rst = 1'b1; bus.wready = '0; flush();
      length = '{6'd5, 6'd0, 6'd0, 6'd0};
      tick();
      rst = 1'b0; bus.wready = 4'b0001;
      for (int k = 0; k < 5; k++) push(0, k);
      for (int n = 0; n < 7; n++) tick();
      chk("t6_exhausted_write", int'(bus.write[0]), 0);
      chk("t6_exhausted_out", int'(bus.out[0]), int'(data[4]));
      push(0, 5); push(0, 6);
      length[0] = 6'd7;
      tick();
      chk("t6_resume_write", int'(bus.write[0]), 1);
      chk("t6_resume_out", int'(bus.out[0]), int'(data[5]));
      tick();
      chk("t6_second_out", int'(bus.out[0]), int'(data[6]));
      tick();
      chk("t6_end_write", int'(bus.write[0]), 0);
      chk("t6_end_out", int'(bus.out[0]), int'(data[6]));
      drained("t6");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
